vxc_chunk_sequencer: RTL and testbench

Controller that runs one complete vector-times-constant-plus-vector job (result = first_row·constant ± second_row, complex elements) through the shared 8-lane complex datapath. On `start` it streams ceil(N/U) chunks from the two operand memories into the datapath, tracks the fixed-latency pipeline, writes each returned chunk to result memory, and signals completion. It replaces the ad-hoc per-module counters and `@(posedge clk)` waits with one synthesizable FSM that sits between the operand/result RAMs and the datapath.

---
 rtl/vxc_seq_pkg.sv | 21 ++
 rtl/vxc_lane_mask.sv | 24 ++
 rtl/vxc_chunk_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_vxc_chunk_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vxc_seq_pkg.sv
// Shared types and helpers for the vector-times-constant chunk sequencer.
// Holds the FSM state encoding and the chunk-count arithmetic.
package vxc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    localparam int DEF_N = 19;
    localparam int DEF_U = 8;
    localparam int C = ceil_div(DEF_N, DEF_U);
    localparam int LAST_LANES = DEF_N - (C - 1) * DEF_U;

endpackage

// File: rtl/vxc_lane_mask.sv
// Zeroes the pad lanes of the final chunk; only built with VXC_SEQ_PAD_ZERO_EN.
// Lanes below valid_lanes always pass through unchanged.
`ifdef VXC_SEQ_PAD_ZERO_EN
module vxc_lane_mask #(
    parameter int ELEMENT_WIDTH = 64,
    parameter int NO_OF_UNITS = 8,
    parameter int VALID_LANES = 8
) (
    input  logic                                 last,
    input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] data,
    output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] masked
);

    always_comb begin
        masked = data;
        for (int i = VALID_LANES; i < NO_OF_UNITS; i++) begin
            if (last) begin
                masked[i*ELEMENT_WIDTH +: ELEMENT_WIDTH] = '0;
            end
        end
    end

endmodule
`endif

// File: rtl/vxc_chunk_sequencer.sv
// Streams one result = a*constant +/- b job through the 8-lane datapath.
// Define VXC_SEQ_PAD_ZERO_EN to zero the pad lanes of the last chunk.
module vxc_chunk_sequencer
    import vxc_seq_pkg::*;
#(
    parameter int NUMBER_OF_EQUATIONS = 19,
    parameter int NO_OF_UNITS = 8,
    parameter int ELEMENT_WIDTH = 64,
    parameter int PIPE_LATENCY = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 op,
    input  logic [ELEMENT_WIDTH-1:0]             constant,
    output logic                                 rd_en,
    output logic [ADDR_WIDTH-1:0]                rd_addr,
    input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] rd_data_a,
    input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] rd_data_b,
    output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] dp_first_row,
    output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] dp_second_row,
    output logic [ELEMENT_WIDTH-1:0]             dp_constant,
    output logic                                 dp_op,
    output logic                                 dp_valid_in,
    input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] dp_result,
    input  logic                                 dp_valid_out,
    output logic                                 wr_en,
    output logic [ADDR_WIDTH-1:0]                wr_addr,
    output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] wr_data,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err_unexpected
);

    localparam int CHUNKS = ceil_div(NUMBER_OF_EQUATIONS, NO_OF_UNITS);
    localparam int DW = ELEMENT_WIDTH * NO_OF_UNITS;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(CHUNKS - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    if (CHUNKS > (1 << ADDR_WIDTH) || PIPE_LATENCY < 1) begin : g_bad_cfg
        $error("vxc_chunk_sequencer: chunk count or latency out of range");
    end

    state_t state;
    state_t state_nx;

    logic [ADDR_WIDTH-1:0] rd_cnt;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic [ADDR_WIDTH-1:0] rx_cnt;
    logic                  rx_full;
    logic                  rd_en_d1;
    logic                  accept_start;
    logic                  accept_res;
    logic [DW-1:0]         row_a;
    logic [DW-1:0]         row_b;

    assign accept_start = start && (state == IDLE);
    assign accept_res   = dp_valid_out && !rx_full &&
                          (state == ISSUE || state == DRAIN);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rd_en    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = ISSUE;
            end
            ISSUE: begin
                rd_en = 1'b1;
                busy  = 1'b1;
                if (rd_cnt == LAST_IDX) state_nx = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // Leave on the final write so done lands right after it.
                if (wr_en && wr_cnt == LAST_IDX) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign rd_addr = rd_cnt;
    assign wr_addr = wr_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_cnt <= '0;
        end else if (rd_en) begin
            rd_cnt <= (rd_cnt == LAST_IDX) ? '0 : rd_cnt + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dp_constant <= '0;
            dp_op       <= 1'b0;
        end else if (accept_start) begin
            dp_constant <= constant;
            dp_op       <= op;
        end
    end

`ifdef VXC_SEQ_PAD_ZERO_EN
    localparam int TAIL = NUMBER_OF_EQUATIONS - (CHUNKS - 1) * NO_OF_UNITS;

    logic last_d1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_d1 <= 1'b0;
        end else begin
            last_d1 <= rd_en && (rd_cnt == LAST_IDX);
        end
    end

    vxc_lane_mask #(
        .ELEMENT_WIDTH(ELEMENT_WIDTH),
        .NO_OF_UNITS  (NO_OF_UNITS),
        .VALID_LANES  (TAIL)
    ) u_mask_a (
        .last  (last_d1),
        .data  (rd_data_a),
        .masked(row_a)
    );

    vxc_lane_mask #(
        .ELEMENT_WIDTH(ELEMENT_WIDTH),
        .NO_OF_UNITS  (NO_OF_UNITS),
        .VALID_LANES  (TAIL)
    ) u_mask_b (
        .last  (last_d1),
        .data  (rd_data_b),
        .masked(row_b)
    );
`else
    assign row_a = rd_data_a;
    assign row_b = rd_data_b;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_en_d1      <= 1'b0;
            dp_valid_in   <= 1'b0;
            dp_first_row  <= '0;
            dp_second_row <= '0;
        end else begin
            rd_en_d1    <= rd_en;
            dp_valid_in <= rd_en_d1;
            if (rd_en_d1) begin
                dp_first_row  <= row_a;
                dp_second_row <= row_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_cnt  <= '0;
            rx_full <= 1'b0;
        end else if (accept_start) begin
            rx_cnt  <= '0;
            rx_full <= 1'b0;
        end else if (accept_res) begin
            if (rx_cnt == LAST_IDX) rx_full <= 1'b1;
            else rx_cnt <= rx_cnt + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_en   <= 1'b0;
            wr_data <= '0;
            wr_cnt  <= '0;
        end else begin
            wr_en <= accept_res;
            if (accept_res) wr_data <= dp_result;
            if (accept_start) wr_cnt <= '0;
            else if (wr_en) wr_cnt <= wr_cnt + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_unexpected <= 1'b0;
        end else if (dp_valid_out && !accept_res) begin
            err_unexpected <= 1'b1;
        end else if (accept_start) begin
            err_unexpected <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vxc_chunk_sequencer.sv
// Scoreboard bench for vxc_chunk_sequencer with RAM and datapath models.
// Honours VXC_SEQ_PAD_ZERO_EN when computing expected pad lanes.
module tb_vxc_chunk_sequencer;

    localparam int N  = 19;
    localparam int U  = 8;
    localparam int EW = 64;
    localparam int L  = 4;
    localparam int AW = 8;
    localparam int C  = (N + U - 1) / U;
    localparam int DW = EW * U;
`ifdef VXC_SEQ_PAD_ZERO_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          op = 1'b0;
    logic [EW-1:0] constant = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data_a = '0;
    logic [DW-1:0] rd_data_b = '0;
    logic [DW-1:0] dp_first_row, dp_second_row, dp_result;
    logic [EW-1:0] dp_constant;
    logic          dp_op, dp_valid_in, dp_valid_out;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy, done, err_unexpected;

    vxc_chunk_sequencer #(
        .NUMBER_OF_EQUATIONS(N), .NO_OF_UNITS(U), .ELEMENT_WIDTH(EW),
        .PIPE_LATENCY(L), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .constant(constant), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .dp_first_row(dp_first_row), .dp_second_row(dp_second_row),
        .dp_constant(dp_constant), .dp_op(dp_op),
        .dp_valid_in(dp_valid_in), .dp_result(dp_result),
        .dp_valid_out(dp_valid_out), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done),
        .err_unexpected(err_unexpected)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nfail = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s @%0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Element layout: real in [31:0], imaginary in [63:32].
    function automatic logic [63:0] cmac(input logic [63:0] a,
                                         input logic [63:0] b,
                                         input logic [63:0] c,
                                         input logic o);
        logic [31:0] pr, pi, rr, ri;
        pr = a[31:0] * c[31:0] - a[63:32] * c[63:32];
        pi = a[31:0] * c[63:32] + a[63:32] * c[31:0];
        rr = o ? pr - b[31:0] : pr + b[31:0];
        ri = o ? pi - b[63:32] : pi + b[63:32];
        return {ri, rr};
    endfunction

    logic [EW-1:0] mem_a [C*U];
    logic [EW-1:0] mem_b [C*U];

    always @(posedge clk) begin
        if (rd_en) begin
            for (int l = 0; l < U; l++) begin
                rd_data_a[l*EW +: EW] <= mem_a[(int'(rd_addr) % C) * U + l];
                rd_data_b[l*EW +: EW] <= mem_b[(int'(rd_addr) % C) * U + l];
            end
        end
    end

    function automatic logic [DW-1:0] dp_compute(input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b,
                                                 input logic [EW-1:0] c,
                                                 input logic o);
        logic [DW-1:0] r;
        for (int l = 0; l < U; l++)
            r[l*EW +: EW] = cmac(a[l*EW +: EW], b[l*EW +: EW], c, o);
        return r;
    endfunction

    logic [L-1:0]  pv = '0;
    logic [DW-1:0] pr [L];
    logic          spur = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            pv <= '0;
        end else begin
            pv <= {pv[L-2:0], dp_valid_in};
            pr[0] <= dp_compute(dp_first_row, dp_second_row,
                                dp_constant, dp_op);
            for (int s = 1; s < L; s++) pr[s] <= pr[s-1];
        end
    end

    assign dp_valid_out = pv[L-1] | spur;
    assign dp_result    = pr[L-1];

    typedef struct {
        int            addr;
        logic [DW-1:0] data;
        int            when;
    } wr_t;

    wr_t           wq[$];
    int            c0 = 0;
    bit            job_active = 1'b0;
    logic          job_op = 1'b0;
    logic [EW-1:0] job_c = '0;

    function automatic logic [DW-1:0] exp_row(input bit second, input int k);
        logic [DW-1:0] r;
        for (int l = 0; l < U; l++) begin
            int i;
            i = k * U + l;
            r[l*EW +: EW] = (PAD && i >= N) ? '0 :
                            (second ? mem_b[i] : mem_a[i]);
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] exp_chunk(input int k);
        logic [DW-1:0] r;
        for (int l = 0; l < U; l++) begin
            int i;
            i = k * U + l;
            r[l*EW +: EW] = (PAD && i >= N) ? '0 :
                            cmac(mem_a[i], mem_b[i], job_c, job_op);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        int rel;
        rel = cyc - c0;
        if (job_active) begin
            chk("busy", DW'(busy), DW'(rel >= 1 && rel <= C + 4 + L));
            chk("rd_en", DW'(rd_en), DW'(rel >= 1 && rel <= C));
            if (rel >= 1 && rel <= C)
                chk("rd_addr", DW'(rd_addr), DW'(rel - 1));
            chk("dp_valid_in", DW'(dp_valid_in), DW'(rel >= 3 && rel <= C + 2));
            if (rel >= 3 && rel <= C + 2) begin
                chk("dp_first_row", dp_first_row, exp_row(1'b0, rel - 3));
                chk("dp_second_row", dp_second_row, exp_row(1'b1, rel - 3));
                chk("dp_constant", DW'(dp_constant), DW'(job_c));
                chk("dp_op", DW'(dp_op), DW'(job_op));
            end
            chk("done", DW'(done), DW'(rel == C + 4 + L));
        end else begin
            chk("done_idle", DW'(done), '0);
        end
        if (wr_en) begin
            if (wq.size() == 0) begin
                chk("unexpected_wr_en", DW'(wr_en), '0);
            end else begin
                wr_t e;
                e = wq.pop_front();
                chk("wr_cycle", DW'(cyc), DW'(e.when));
                chk("wr_addr", DW'(wr_addr), DW'(e.addr));
                chk("wr_data", wr_data, e.data);
            end
        end
        if (wq.size() > 0 && wq[0].when < cyc) begin
            chk("missed_write", DW'(cyc), DW'(wq[0].when));
            void'(wq.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        logic [DW-1:0] any;
        any = DW'({rd_en, busy, done, err_unexpected, wr_en, dp_op,
                   dp_valid_in, rd_addr, wr_addr});
        chk({tag, "_ctrl"}, any, '0);
        chk({tag, "_rows"}, dp_first_row | dp_second_row, '0);
        chk({tag, "_const"}, DW'(dp_constant), '0);
        chk({tag, "_wr_data"}, wr_data, '0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < C * U; i++) begin
            mem_a[i] = {$urandom, $urandom};
            mem_b[i] = {$urandom, $urandom};
        end
    endtask

    task automatic run_job(input logic op_i, input logic [EW-1:0] c_i,
                           input int xa, input int xb, input int abort_rel);
        job_op = op_i;
        job_c  = c_i;
        for (int k = 0; k < C; k++)
            wq.push_back('{k, exp_chunk(k), cyc + 4 + L + k});
        c0 = cyc;
        job_active = 1'b1;
        start = 1'b1;
        op = op_i;
        constant = c_i;
        for (int rel = 1; rel <= C + 5 + L; rel++) begin
            tick();
            start = (rel == xa || rel == xb);
            op = 1'($urandom);
            constant = {$urandom, $urandom};
            if (rel == 1) chk("err_cleared", DW'(err_unexpected), '0);
            if (rel == abort_rel) begin
                reset = 1'b0;
                job_active = 1'b0;
                wq.delete();
                tick();
                check_all_zero("abort");
                reset = 1'b1;
                tick();
                tick();
                return;
            end
        end
        chk("err_end", DW'(err_unexpected), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        for (int i = 0; i < C * U; i++) begin
            mem_a[i] = {32'd0, 32'(i)};
            mem_b[i] = {32'd0, 32'd100};
        end
        run_job(1'b0, {32'd0, 32'd1}, 2, C + 4 + L, 0);

        for (int i = 0; i < C * U; i++) begin
            mem_a[i] = '1;
            mem_b[i] = '1;
        end
        run_job(1'b1, {$urandom, $urandom}, 0, 0, 0);

        for (int j = 0; j < 3; j++) begin
            fill_random();
            run_job(1'($urandom), {$urandom, $urandom}, 0, 0, 0);
        end

        fill_random();
        run_job(1'b0, {$urandom, $urandom}, 0, 0, 6);
        fill_random();
        run_job(1'($urandom), {$urandom, $urandom}, 0, 0, 0);

        spur = 1'b1;
        tick();
        spur = 1'b0;
        chk("spur_no_wr", DW'(wr_en), '0);
        tick();
        chk("spur_err_set", DW'(err_unexpected), DW'(1));
        tick();
        tick();
        tick();
        chk("spur_err_sticky", DW'(err_unexpected), DW'(1));
        fill_random();
        run_job(1'($urandom), {$urandom, $urandom}, 0, 0, 0);

        tick();
        tick();
        chk("queue_drained", DW'(wq.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
